// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//
// Write-back stage in front of the 4-register file's single write port. Each cycle it
// picks the oldest pending result (buffered FIFO head, then a returning load, then the
// ALU result) and registers it onto reg_write/write_addr/write_data. Results that lose
// the port are queued in order in a small collision FIFO. A per-register scoreboard
// tracks outstanding loads, and stall warns upstream when fewer than two FIFO slots remain.
//
// Optional feature macro: WB_FWD_EN adds combinational forwarding lookup ports.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   alu_valid/addr/data     ALU result candidate
//   load_issue/_addr        load dispatch, marks destination pending
//   load_valid/addr/data    returned load candidate
//   reg_write/write_addr/write_data  registered register-file write port
//   pending           per-register outstanding-load bits
//   stall             fewer than 2 free FIFO entries (from registered count)
//   overflow          sticky, a result was dropped because the FIFO was full
//   fwd_addr/fwd_hit/fwd_data  (WB_FWD_EN only) youngest in-flight value for fwd_addr

module writeback_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              load_issue,
  input  logic [ADDR_W-1:0] load_issue_addr,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic [3:0]        pending,
  output logic              stall,
  output logic              overflow
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // FIFO storage: {is_load, addr, data} per entry
  logic              fifo_is_load [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr    [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data    [FIFO_DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Selected output candidate
  logic              out_v;
  logic              out_is_load;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  // Up to two candidates to enqueue, already in age order
  logic              e0_v, e1_v;
  logic              e0_is_load, e1_is_load;
  logic [ADDR_W-1:0] e0_addr, e1_addr;
  logic [DATA_W-1:0] e0_data, e1_data;

  logic              head_v;
  logic              acc0, acc1;
  logic              drop;
  logic [CNT_W-1:0]  free_after_pop;
  logic [3:0]        pending_d;

  // Candidate selection: head, then load, then ALU. Losers are enqueued in that order.
  always_comb begin
    head_v      = (count_q != '0);
    out_v       = 1'b0;
    out_is_load = 1'b0;
    out_addr    = '0;
    out_data    = '0;
    e0_v        = 1'b0;
    e0_is_load  = 1'b0;
    e0_addr     = '0;
    e0_data     = '0;
    e1_v        = 1'b0;
    e1_is_load  = 1'b0;
    e1_addr     = '0;
    e1_data     = '0;

    if (head_v) begin
      out_v       = 1'b1;
      out_is_load = fifo_is_load[rd_ptr_q];
      out_addr    = fifo_addr[rd_ptr_q];
      out_data    = fifo_data[rd_ptr_q];
      if (load_valid) begin
        e0_v       = 1'b1;
        e0_is_load = 1'b1;
        e0_addr    = load_addr;
        e0_data    = load_data;
        if (alu_valid) begin
          e1_v    = 1'b1;
          e1_addr = alu_addr;
          e1_data = alu_data;
        end
      end else if (alu_valid) begin
        e0_v    = 1'b1;
        e0_addr = alu_addr;
        e0_data = alu_data;
      end
    end else if (load_valid) begin
      out_v       = 1'b1;
      out_is_load = 1'b1;
      out_addr    = load_addr;
      out_data    = load_data;
      if (alu_valid) begin
        e0_v    = 1'b1;
        e0_addr = alu_addr;
        e0_data = alu_data;
      end
    end else if (alu_valid) begin
      out_v    = 1'b1;
      out_addr = alu_addr;
      out_data = alu_data;
    end
  end

  // Space is evaluated after the head pop; anything that still does not fit is dropped.
  always_comb begin
    free_after_pop = CNT_W'(FIFO_DEPTH) - count_q + CNT_W'(head_v);
    acc0           = e0_v && (free_after_pop >= CNT_W'(1));
    acc1           = e1_v && (free_after_pop >= CNT_W'(2));
    drop           = (e0_v && !acc0) || (e1_v && !acc1);
    count_d        = count_q - CNT_W'(head_v) + CNT_W'(acc0) + CNT_W'(acc1);
    rd_ptr_d       = rd_ptr_q + PTR_W'(head_v);
    wr_ptr_d       = wr_ptr_q + PTR_W'(acc0) + PTR_W'(acc1);
  end

  // Scoreboard: clear on a latched load write, then set from a new issue so set wins.
  always_comb begin
    pending_d = pending;
    if (out_v && out_is_load) begin
      pending_d[out_addr] = 1'b0;
    end
    if (load_issue) begin
      pending_d[load_issue_addr] = 1'b1;
    end
  end

  assign stall = (count_q > CNT_W'(FIFO_DEPTH - 2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write  <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      pending    <= '0;
      overflow   <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      reg_write <= out_v;
      if (out_v) begin
        write_addr <= out_addr;
        write_data <= out_data;
      end
      pending  <= pending_d;
      if (drop) begin
        overflow <= 1'b1;
      end
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage needs no reset; validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (acc0) begin
      fifo_is_load[wr_ptr_q] <= e0_is_load;
      fifo_addr[wr_ptr_q]    <= e0_addr;
      fifo_data[wr_ptr_q]    <= e0_data;
    end
    if (acc1) begin
      fifo_is_load[wr_ptr_q + PTR_W'(1)] <= e1_is_load;
      fifo_addr[wr_ptr_q + PTR_W'(1)]    <= e1_addr;
      fifo_data[wr_ptr_q + PTR_W'(1)]    <= e1_data;
    end
  end

`ifdef WB_FWD_EN
  // Walk oldest to youngest so the last match is the youngest; the output register
  // is older than every FIFO entry and only wins if nothing in the FIFO matches.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    if (reg_write && (write_addr == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = write_data;
    end
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (fifo_addr[idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_data[idx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter (FIFO_DEPTH=4, DATA_W=8, ADDR_W=2).
module tb_writeback_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       alu_valid;
  logic [1:0] alu_addr;
  logic [7:0] alu_data;
  logic       load_issue;
  logic [1:0] load_issue_addr;
  logic       load_valid;
  logic [1:0] load_addr;
  logic [7:0] load_data;
  logic       reg_write;
  logic [1:0] write_addr;
  logic [7:0] write_data;
  logic [3:0] pending;
  logic       stall;
  logic       overflow;
`ifdef WB_FWD_EN
  logic [1:0] fwd_addr;
  logic       fwd_hit;
  logic [7:0] fwd_data;
`endif

  int vectors = 0;
  int miscompares = 0;

  writeback_arbiter #(
    .FIFO_DEPTH(4),
    .DATA_W    (8),
    .ADDR_W    (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_addr       (alu_addr),
    .alu_data       (alu_data),
    .load_issue     (load_issue),
    .load_issue_addr(load_issue_addr),
    .load_valid     (load_valid),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .reg_write      (reg_write),
    .write_addr     (write_addr),
    .write_data     (write_data),
    .pending        (pending),
    .stall          (stall),
    .overflow       (overflow)
`ifdef WB_FWD_EN
    ,
    .fwd_addr       (fwd_addr),
    .fwd_hit        (fwd_hit),
    .fwd_data       (fwd_data)
`endif
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, then sample 1 time unit after the capturing edge.
  task automatic drive(input logic av, input logic [1:0] aa, input logic [7:0] ad,
                       input logic lv, input logic [1:0] la, input logic [7:0] ld,
                       input logic li, input logic [1:0] lia);
    alu_valid       = av;
    alu_addr        = aa;
    alu_data        = ad;
    load_valid      = lv;
    load_addr       = la;
    load_data       = ld;
    load_issue      = li;
    load_issue_addr = lia;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    load_valid = 1'b0; load_addr = '0; load_data = '0;
    load_issue = 1'b0; load_issue_addr = '0;
`ifdef WB_FWD_EN
    fwd_addr = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({reg_write, write_addr, write_data} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_port: got %b/%0d/%h want 0/0/00", reg_write, write_addr, write_data);
    end
    vectors++;
    if ({pending, stall, overflow} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_status: got pend=%b stall=%b ovf=%b want 0000/0/0",
               pending, stall, overflow);
    end
    reset = 1'b0;
    idle();
  endtask

  task automatic test_uncontended();
    drive(1'b1, 2'd2, 8'h5A, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    vectors++;
    if ({reg_write, write_addr, write_data} !== {1'b1, 2'd2, 8'h5A}) begin
      miscompares++;
      $display("FAIL uncontended_write: got %b/%0d/%h want 1/2/5a",
               reg_write, write_addr, write_data);
    end
    idle();
    vectors++;
    if ({reg_write, write_addr, write_data} !== {1'b0, 2'd2, 8'h5A}) begin
      miscompares++;
      $display("FAIL uncontended_idle_hold: got %b/%0d/%h want 0/2/5a",
               reg_write, write_addr, write_data);
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 2'd3, 8'h33, 1'b1, 2'd1, 8'h11, 1'b0, 2'd0);
    vectors++;
    if ({reg_write, write_addr, write_data, stall} !== {1'b1, 2'd1, 8'h11, 1'b0}) begin
      miscompares++;
      $display("FAIL collision_first: got %b/%0d/%h stall=%b want 1/1/11 stall=0",
               reg_write, write_addr, write_data, stall);
    end
    idle();
    vectors++;
    if ({reg_write, write_addr, write_data} !== {1'b1, 2'd3, 8'h33}) begin
      miscompares++;
      $display("FAIL collision_second: got %b/%0d/%h want 1/3/33",
               reg_write, write_addr, write_data);
    end
    idle();
    vectors++;
    if (reg_write !== 1'b0) begin
      miscompares++;
      $display("FAIL collision_drained: got reg_write=%b want 0", reg_write);
    end
  endtask

  task automatic test_scoreboard();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
    vectors++;
    if ({pending, reg_write} !== {4'b0001, 1'b0}) begin
      miscompares++;
      $display("FAIL sb_set: got pend=%b rw=%b want 0001/0", pending, reg_write);
    end
    idle();
    idle();
    vectors++;
    if (pending !== 4'b0001) begin
      miscompares++;
      $display("FAIL sb_hold: got pend=%b want 0001", pending);
    end
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'hC3, 1'b0, 2'd0);
    vectors++;
    if ({pending, reg_write, write_addr, write_data} !== {4'b0000, 1'b1, 2'd0, 8'hC3}) begin
      miscompares++;
      $display("FAIL sb_clear: got pend=%b %b/%0d/%h want 0000 1/0/c3",
               pending, reg_write, write_addr, write_data);
    end
    // Issue and completion to the same register in one cycle: the set wins.
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h44, 1'b1, 2'd1);
    vectors++;
    if ({pending, reg_write, write_addr, write_data} !== {4'b0010, 1'b1, 2'd1, 8'h44}) begin
      miscompares++;
      $display("FAIL sb_set_wins: got pend=%b %b/%0d/%h want 0010 1/1/44",
               pending, reg_write, write_addr, write_data);
    end
    drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 8'h45, 1'b0, 2'd0);
    vectors++;
    if (pending !== 4'b0000) begin
      miscompares++;
      $display("FAIL sb_second_clear: got pend=%b want 0000", pending);
    end
    idle();
  endtask

  task automatic test_fill_overflow();
    logic [1:0] exp_addr [$];
    logic [7:0] exp_data [$];
    logic       exp_stall [5];
    int         seen;
    int         budget;
    exp_stall[0] = 1'b0; exp_stall[1] = 1'b0; exp_stall[2] = 1'b1;
    exp_stall[3] = 1'b1; exp_stall[4] = 1'b1;
    // Five load+ALU collisions; the final ALU result finds the FIFO full and is lost.
    for (int k = 0; k < 5; k++) begin
      logic [1:0] la;
      logic [1:0] aa;
      la = 2'(k);
      aa = 2'(3 - (k % 4));
      exp_addr.push_back(la);
      exp_data.push_back(8'h10 + 8'(k));
      if (k < 4) begin
        exp_addr.push_back(aa);
        exp_data.push_back(8'h80 + 8'(k));
      end
    end
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 2'(3 - (k % 4)), 8'h80 + 8'(k), 1'b1, 2'(k), 8'h10 + 8'(k), 1'b0, 2'd0);
      vectors++;
      if ({reg_write, write_addr, write_data} !== {1'b1, exp_addr[seen], exp_data[seen]}) begin
        miscompares++;
        $display("FAIL fill_write%0d: got %b/%0d/%h want 1/%0d/%h", seen, reg_write,
                 write_addr, write_data, exp_addr[seen], exp_data[seen]);
      end
      seen++;
      vectors++;
      if (stall !== exp_stall[k]) begin
        miscompares++;
        $display("FAIL fill_stall%0d: got %b want %b", k, stall, exp_stall[k]);
      end
      vectors++;
      if (overflow !== (k == 4)) begin
        miscompares++;
        $display("FAIL fill_overflow%0d: got %b want %b", k, overflow, (k == 4));
      end
    end
    budget = 10;
    while (seen < 9 && budget > 0) begin
      idle();
      budget--;
      vectors++;
      if ({reg_write, write_addr, write_data} !== {1'b1, exp_addr[seen], exp_data[seen]}) begin
        miscompares++;
        $display("FAIL drain_write%0d: got %b/%0d/%h want 1/%0d/%h", seen, reg_write,
                 write_addr, write_data, exp_addr[seen], exp_data[seen]);
      end
      seen++;
    end
    idle();
    vectors++;
    if ({reg_write, stall, overflow} !== 3'b001) begin
      miscompares++;
      $display("FAIL fill_end: got rw=%b stall=%b ovf=%b want 0/0/1", reg_write, stall, overflow);
    end
  endtask

  task automatic test_reset_mid_burst();
    drive(1'b1, 2'd1, 8'hBB, 1'b1, 2'd0, 8'hAA, 1'b1, 2'd3);
    drive(1'b1, 2'd3, 8'hDD, 1'b1, 2'd2, 8'hCC, 1'b0, 2'd0);
    vectors++;
    if ({reg_write, write_data, pending} !== {1'b1, 8'hBB, 4'b1000}) begin
      miscompares++;
      $display("FAIL burst_pre: got rw=%b data=%h pend=%b want 1/bb/1000",
               reg_write, write_data, pending);
    end
    alu_valid  = 1'b0;
    load_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    vectors++;
    if ({reg_write, pending, overflow, stall} !== 7'd0) begin
      miscompares++;
      $display("FAIL async_reset: got rw=%b pend=%b ovf=%b stall=%b want 0/0000/0/0",
               reg_write, pending, overflow, stall);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      idle();
      vectors++;
      if (reg_write !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset%0d: got rw=%b addr=%0d data=%h want rw=0",
                 k, reg_write, write_addr, write_data);
      end
    end
  endtask

`ifdef WB_FWD_EN
  task automatic test_forward();
    drive(1'b1, 2'd0, 8'h02, 1'b1, 2'd0, 8'h01, 1'b0, 2'd0);
    drive(1'b1, 2'd2, 8'h20, 1'b1, 2'd2, 8'h10, 1'b0, 2'd0);
    alu_valid  = 1'b0;
    load_valid = 1'b0;
    fwd_addr = 2'd2;
    #1;
    vectors++;
    if ({fwd_hit, fwd_data} !== {1'b1, 8'h20}) begin
      miscompares++;
      $display("FAIL fwd_youngest: got %b/%h want 1/20", fwd_hit, fwd_data);
    end
    fwd_addr = 2'd0;
    #1;
    vectors++;
    if ({fwd_hit, fwd_data} !== {1'b1, 8'h02}) begin
      miscompares++;
      $display("FAIL fwd_outreg: got %b/%h want 1/02", fwd_hit, fwd_data);
    end
    fwd_addr = 2'd1;
    #1;
    vectors++;
    if (fwd_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL fwd_miss: got %b want 0", fwd_hit);
    end
    idle();
    idle();
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_uncontended();
    test_collision();
    test_scoreboard();
    test_fill_overflow();
    test_reset_mid_burst();
`ifdef WB_FWD_EN
    test_forward();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
